// File: rtl/fir_ctrl_pkg.sv
// Shared encodings and defaults for the FIR coefficient SRAM sequencer.
package fir_ctrl_pkg;

  localparam int unsigned COEFF_W = 16;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned NUM_W   = 6;
  localparam int unsigned N_W     = 5;
  localparam int unsigned CNT_W   = 4;

  localparam int unsigned DEF_NUM_COEFF = 12;
  localparam int unsigned DEF_POS_TAPS  = 7;
  localparam int unsigned DEF_NEG_TAPS  = 5;
  localparam int unsigned DEF_ACC_CYC   = 8;
  localparam int unsigned SAMPLE_PERIOD = 20;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    RUN_WAIT = 2'd2,
    ACC      = 2'd3
  } fir_state_e;

  // One filter RAM port cycle: chip select, write enable, both bank addresses, data, index.
  typedef struct packed {
    logic               csn;
    logic               wrn;
    logic [ADDR_W-1:0]  addr_pos;
    logic [ADDR_W-1:0]  addr_neg;
    logic [COEFF_W-1:0] wr_data;
    logic [NUM_W-1:0]   num;
  } ram_port_t;

  localparam ram_port_t RAM_IDLE = '{csn: 1'b1, wrn: 1'b1, addr_pos: '0,
                                     addr_neg: '0, wr_data: '0, num: '0};

endpackage

// File: rtl/fir_coeff_seq_ctrl_if.sv
// Host coefficient stream, sample strobe and filter RAM control bundle.
interface fir_coeff_seq_ctrl_if;
  import fir_ctrl_pkg::*;

  logic               iEnSample_600k;
  logic               iLoadStart;
  logic               iCoeffValid;
  logic [COEFF_W-1:0] iCoeffData;
  logic               oCoeffReady;
  logic               oLoadDone;
  logic               oRunEn;
  logic               oCoeffiUpdateFlag;
  logic               oCsnRam;
  logic               oWrnRam;
  logic [ADDR_W-1:0]  oAddrRam_pos;
  logic [ADDR_W-1:0]  oAddrRam_neg;
  logic [COEFF_W-1:0] oWrDtRam;
  logic [NUM_W-1:0]   oNumOfCoeff;

  modport master (
    output iEnSample_600k, iLoadStart, iCoeffValid, iCoeffData,
    input  oCoeffReady, oLoadDone, oRunEn, oCoeffiUpdateFlag, oCsnRam, oWrnRam,
           oAddrRam_pos, oAddrRam_neg, oWrDtRam, oNumOfCoeff
  );

  modport slave (
    input  iEnSample_600k, iLoadStart, iCoeffValid, iCoeffData,
    output oCoeffReady, oLoadDone, oRunEn, oCoeffiUpdateFlag, oCsnRam, oWrnRam,
           oAddrRam_pos, oAddrRam_neg, oWrDtRam, oNumOfCoeff
  );

endinterface

// File: rtl/fir_tap_addr_gen.sv
// ACC cycle counter with saturating pos/neg read addresses; addresses are
// presented as next-cycle values so the parent can register them with no extra latency.
module fir_tap_addr_gen
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned P_POS_TAPS = DEF_POS_TAPS,
  parameter int unsigned P_NEG_TAPS = DEF_NEG_TAPS,
  parameter int unsigned P_ACC_CYC  = DEF_ACC_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_clear,
  output logic              o_last_c,
  output logic [ADDR_W-1:0] o_pos_c,
  output logic [ADDR_W-1:0] o_neg_c
);

  localparam logic [CNT_W-1:0] LP_ACC     = CNT_W'(P_ACC_CYC);
  localparam logic [CNT_W-1:0] LP_POS_MAX = CNT_W'(P_POS_TAPS);
  localparam logic [CNT_W-1:0] LP_NEG_MAX = CNT_W'(P_NEG_TAPS);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // c runs 1..P_ACC_CYC during a sweep and rests at 0 otherwise
  always_comb begin
    w_cnt_nxt = '0;
    if (i_clear) begin
      w_cnt_nxt = '0;
    end else if (i_start) begin
      w_cnt_nxt = CNT_W'(1);
    end else if ((r_cnt != '0) && (r_cnt != LP_ACC)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  assign o_last_c = (r_cnt == LP_ACC);
  assign o_pos_c  = ADDR_W'((w_cnt_nxt > LP_POS_MAX) ? LP_POS_MAX : w_cnt_nxt);
  assign o_neg_c  = ADDR_W'((w_cnt_nxt > LP_NEG_MAX) ? LP_NEG_MAX : w_cnt_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/fir_coeff_seq_ctrl.sv
// FIR coefficient SRAM sequencer: host load into pos/neg banks, then one read
// sweep of both banks per sample strobe.
module fir_coeff_seq_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned P_NUM_COEFF = DEF_NUM_COEFF,
  parameter int unsigned P_POS_TAPS  = DEF_POS_TAPS,
  parameter int unsigned P_NEG_TAPS  = DEF_NEG_TAPS,
  parameter int unsigned P_ACC_CYC   = DEF_ACC_CYC
) (
  input  logic                  iClk_12M,
  input  logic                  iRsn,
  fir_coeff_seq_ctrl_if.slave   bus
);

  localparam logic [N_W-1:0]    LP_LAST_N   = N_W'(P_NUM_COEFF);
  localparam logic [ADDR_W-1:0] LP_CTR_ADDR = ADDR_W'(P_POS_TAPS);

  fir_state_e       r_state, w_state_nxt;
  ram_port_t        r_ram, w_ram_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_done, w_done_nxt;
  logic             r_run_en, w_run_en_nxt;
  logic             r_flag, w_flag_nxt;
  logic             r_load_pend, w_load_pend_nxt;
  logic [N_W-1:0]   r_n, w_n_nxt, w_n_inc;
  logic             w_xfer, w_start, w_go_load, w_acc_last;
  logic [ADDR_W-1:0] w_acc_pos, w_acc_neg;

  assign w_xfer    = bus.iCoeffValid & r_ready;
  assign w_n_inc   = r_n + N_W'(1);
  assign w_start   = (r_state == RUN_WAIT) & bus.iEnSample_600k & ~bus.iLoadStart;
  // A load request during ACC waits for the sweep to finish
  assign w_go_load = (bus.iLoadStart && (r_state != ACC)) ||
                     ((r_state == ACC) && w_acc_last && (r_load_pend || bus.iLoadStart));

  fir_tap_addr_gen #(
    .P_POS_TAPS (P_POS_TAPS),
    .P_NEG_TAPS (P_NEG_TAPS),
    .P_ACC_CYC  (P_ACC_CYC)
  ) u_tap_addr_gen (
    .clk      (iClk_12M),
    .rst_n    (iRsn),
    .i_start  (w_start),
    .i_clear  (w_go_load),
    .o_last_c (w_acc_last),
    .o_pos_c  (w_acc_pos),
    .o_neg_c  (w_acc_neg)
  );

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ram_nxt       = r_ram;
    w_ram_nxt.csn   = 1'b1;
    w_ram_nxt.wrn   = 1'b1;
    w_ready_nxt     = 1'b0;
    w_done_nxt      = 1'b0;
    w_flag_nxt      = 1'b0;
    w_run_en_nxt    = r_run_en;
    w_load_pend_nxt = r_load_pend;
    w_n_nxt         = r_n;

    case (r_state)
      IDLE: ;
      LOAD: begin
        w_ready_nxt = 1'b1;
        w_flag_nxt  = 1'b1;
        if (!bus.iLoadStart && w_xfer) begin
          w_n_nxt           = w_n_inc;
          w_ram_nxt.csn     = 1'b0;
          w_ram_nxt.wrn     = 1'b0;
          w_ram_nxt.wr_data = bus.iCoeffData;
          w_ram_nxt.num     = NUM_W'(w_n_inc);
          // Odd h(n) go to pos bank, even to neg bank, final one is the centre tap
          if (w_n_inc[0]) begin
            w_ram_nxt.addr_pos = ADDR_W'((w_n_inc + N_W'(1)) >> 1);
            w_ram_nxt.addr_neg = '0;
          end else if (w_n_inc == LP_LAST_N) begin
            w_ram_nxt.addr_pos = LP_CTR_ADDR;
            w_ram_nxt.addr_neg = '0;
          end else begin
            w_ram_nxt.addr_pos = '0;
            w_ram_nxt.addr_neg = ADDR_W'(w_n_inc >> 1);
          end
          if (w_n_inc == LP_LAST_N) begin
            w_state_nxt  = RUN_WAIT;
            w_ready_nxt  = 1'b0;
            w_done_nxt   = 1'b1;
            w_run_en_nxt = 1'b1;
          end
        end
      end
      RUN_WAIT: begin
        if (w_start) begin
          w_state_nxt        = ACC;
          w_ram_nxt.csn      = 1'b0;
          w_ram_nxt.addr_pos = w_acc_pos;
          w_ram_nxt.addr_neg = w_acc_neg;
        end
      end
      ACC: begin
        if (bus.iLoadStart) begin
          w_load_pend_nxt = 1'b1;
        end
        if (w_acc_last) begin
          w_state_nxt = RUN_WAIT;
        end else begin
          w_ram_nxt.csn      = 1'b0;
          w_ram_nxt.addr_pos = w_acc_pos;
          w_ram_nxt.addr_neg = w_acc_neg;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_go_load) begin
      w_state_nxt     = LOAD;
      w_ready_nxt     = 1'b1;
      w_flag_nxt      = 1'b1;
      w_run_en_nxt    = 1'b0;
      w_load_pend_nxt = 1'b0;
      w_n_nxt         = '0;
    end
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      r_ram       <= RAM_IDLE;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_run_en    <= 1'b0;
      r_flag      <= 1'b0;
      r_load_pend <= 1'b0;
      r_n         <= '0;
    end else begin
      r_ram       <= w_ram_nxt;
      r_ready     <= w_ready_nxt;
      r_done      <= w_done_nxt;
      r_run_en    <= w_run_en_nxt;
      r_flag      <= w_flag_nxt;
      r_load_pend <= w_load_pend_nxt;
      r_n         <= w_n_nxt;
    end
  end

  assign bus.oCoeffReady       = r_ready;
  assign bus.oLoadDone         = r_done;
  assign bus.oRunEn            = r_run_en;
  assign bus.oCoeffiUpdateFlag = r_flag;
  assign bus.oCsnRam           = r_ram.csn;
  assign bus.oWrnRam           = r_ram.wrn;
  assign bus.oAddrRam_pos      = r_ram.addr_pos;
  assign bus.oAddrRam_neg      = r_ram.addr_neg;
  assign bus.oWrDtRam          = r_ram.wr_data;
  assign bus.oNumOfCoeff       = r_ram.num;

endmodule

// File: tb/tb_fir_coeff_seq_ctrl.sv
// Directed bench for fir_coeff_seq_ctrl: vector table for loads, hand sequences for sweeps/reload/reset.
module tb_fir_coeff_seq_ctrl;
  import fir_ctrl_pkg::*;

  typedef struct packed {
    logic       ready, done, run_en, flag, csn, wrn;
    logic [3:0] pos, neg;
    logic [15:0] wd;
    logic [5:0] num;
  } out_t;

  typedef struct {
    logic        li, en, v;
    logic [15:0] d;
    out_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fir_coeff_seq_ctrl_if bus();

  fir_coeff_seq_ctrl dut (
    .iClk_12M (clk),
    .iRsn     (rst_n),
    .bus      (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];
  logic [3:0] acc_pos [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd7};
  logic [3:0] acc_neg [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5};

  function automatic out_t mk(input logic rdy, dn, run, upd, csn, wrn,
                              input int pos, neg, input logic [15:0] wd, input int num);
    out_t o;
    o = '{ready: rdy, done: dn, run_en: run, flag: upd, csn: csn, wrn: wrn,
          pos: 4'(pos), neg: 4'(neg), wd: wd, num: 6'(num)};
    return o;
  endfunction

  function automatic out_t act();
    out_t o;
    o = '{ready: bus.oCoeffReady, done: bus.oLoadDone, run_en: bus.oRunEn,
          flag: bus.oCoeffiUpdateFlag, csn: bus.oCsnRam, wrn: bus.oWrnRam,
          pos: bus.oAddrRam_pos, neg: bus.oAddrRam_neg, wd: bus.oWrDtRam,
          num: bus.oNumOfCoeff};
    return o;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("rdy=%b done=%b run=%b upd=%b csn=%b wrn=%b pos=%0d neg=%0d wd=%h num=%0d",
                     o.ready, o.done, o.run_en, o.flag, o.csn, o.wrn, o.pos, o.neg, o.wd, o.num);
  endfunction

  task automatic chk(input string nm, input out_t e);
    out_t a;
    a = act();
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got {%s} expected {%s}", nm, fmt(a), fmt(e));
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic li, en, v, input logic [15:0] d);
    bus.iLoadStart     = li;
    bus.iEnSample_600k = en;
    bus.iCoeffValid    = v;
    bus.iCoeffData     = d;
  endtask

  task automatic add(input logic li, en, v, input logic [15:0] d, input out_t e);
    vec_t r;
    r.li = li; r.en = en; r.v = v; r.d = d; r.exp = e;
    vecs.push_back(r);
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(vecs[i].li, vecs[i].en, vecs[i].v, vecs[i].d);
      step();
      chk($sformatf("row%0d", i), vecs[i].exp);
    end
    drive(0, 0, 0, 16'h0000);
  endtask

  // One strobe, 8 ACC cycles, then idle out to the next 20-clock boundary
  task automatic sweep(input int ovr, input logic [15:0] wd, input int num, input string nm);
    drive(0, 1, 0, 16'h0000);
    step();
    for (int c = 1; c <= DEF_ACC_CYC; c++) begin
      drive(0, (c == ovr), 0, 16'h0000);
      chk($sformatf("%s_c%0d", nm, c), mk(0, 0, 1, 0, 0, 1, acc_pos[c-1], acc_neg[c-1], wd, num));
      step();
    end
    drive(0, 0, 0, 16'h0000);
    for (int i = 0; i < SAMPLE_PERIOD - DEF_ACC_CYC - 1; i++) begin
      chk($sformatf("%s_idle%0d", nm, i), mk(0, 0, 1, 0, 1, 1, 7, 5, wd, num));
      step();
    end
  endtask

  initial begin
    out_t rst_v;
    int   csn_lo;
    rst_v = mk(0, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 0);

    // Full back-to-back load (rows 0..13)
    add(1, 0, 0, 16'h0000, mk(1, 0, 0, 1, 1, 1, 0, 0, 16'h0000, 0));
    add(0, 0, 1, 16'h0003, mk(1, 0, 0, 1, 0, 0, 1, 0, 16'h0003, 1));
    add(0, 0, 1, 16'h0006, mk(1, 0, 0, 1, 0, 0, 0, 1, 16'h0006, 2));
    add(0, 0, 1, 16'h0007, mk(1, 0, 0, 1, 0, 0, 2, 0, 16'h0007, 3));
    add(0, 0, 1, 16'h000B, mk(1, 0, 0, 1, 0, 0, 0, 2, 16'h000B, 4));
    add(0, 0, 1, 16'h0010, mk(1, 0, 0, 1, 0, 0, 3, 0, 16'h0010, 5));
    add(0, 0, 1, 16'h001A, mk(1, 0, 0, 1, 0, 0, 0, 3, 16'h001A, 6));
    add(0, 0, 1, 16'h0025, mk(1, 0, 0, 1, 0, 0, 4, 0, 16'h0025, 7));
    add(0, 0, 1, 16'h0033, mk(1, 0, 0, 1, 0, 0, 0, 4, 16'h0033, 8));
    add(0, 0, 1, 16'h0040, mk(1, 0, 0, 1, 0, 0, 5, 0, 16'h0040, 9));
    add(0, 0, 1, 16'h005A, mk(1, 0, 0, 1, 0, 0, 0, 5, 16'h005A, 10));
    add(0, 0, 1, 16'h0088, mk(1, 0, 0, 1, 0, 0, 6, 0, 16'h0088, 11));
    add(0, 0, 1, 16'h01F4, mk(0, 1, 1, 1, 0, 0, 7, 0, 16'h01F4, 12));
    add(0, 0, 0, 16'h0000, mk(0, 0, 1, 0, 1, 1, 7, 0, 16'h01F4, 12));
    // Stalled load from RUN_WAIT (rows 14..30)
    add(1, 0, 0, 16'h0000, mk(1, 0, 0, 1, 1, 1, 7, 5, 16'h01F4, 12));
    add(0, 0, 1, 16'h0101, mk(1, 0, 0, 1, 0, 0, 1, 0, 16'h0101, 1));
    add(0, 0, 1, 16'h0102, mk(1, 0, 0, 1, 0, 0, 0, 1, 16'h0102, 2));
    add(0, 0, 1, 16'h0103, mk(1, 0, 0, 1, 0, 0, 2, 0, 16'h0103, 3));
    add(0, 0, 1, 16'h0104, mk(1, 0, 0, 1, 0, 0, 0, 2, 16'h0104, 4));
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 16'hDEAD, mk(1, 0, 0, 1, 1, 1, 0, 2, 16'h0104, 4));
    add(0, 0, 1, 16'h0105, mk(1, 0, 0, 1, 0, 0, 3, 0, 16'h0105, 5));
    add(0, 0, 1, 16'h0106, mk(1, 0, 0, 1, 0, 0, 0, 3, 16'h0106, 6));
    add(0, 0, 1, 16'h0107, mk(1, 0, 0, 1, 0, 0, 4, 0, 16'h0107, 7));
    add(0, 0, 1, 16'h0108, mk(1, 0, 0, 1, 0, 0, 0, 4, 16'h0108, 8));
    add(0, 0, 1, 16'h0109, mk(1, 0, 0, 1, 0, 0, 5, 0, 16'h0109, 9));
    add(0, 0, 1, 16'h010A, mk(1, 0, 0, 1, 0, 0, 0, 5, 16'h010A, 10));
    add(0, 0, 1, 16'h010B, mk(1, 0, 0, 1, 0, 0, 6, 0, 16'h010B, 11));
    add(0, 0, 1, 16'h010C, mk(0, 1, 1, 1, 0, 0, 7, 0, 16'h010C, 12));
    add(0, 0, 0, 16'h0000, mk(0, 0, 1, 0, 1, 1, 7, 0, 16'h010C, 12));

    // Asynchronous reset mid-clock
    drive(0, 0, 0, 16'h0000);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("reset_async", rst_v);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_release", rst_v);

    apply_rows(0, 13);
    sweep(0, 16'h01F4, 12, "sweep1");
    sweep(4, 16'h01F4, 12, "overrun");
    sweep(0, 16'h01F4, 12, "sweep3");
    apply_rows(14, 30);

    // Load request mid-sweep is deferred until the last ACC cycle
    drive(0, 1, 0, 16'h0000);
    step();
    for (int c = 1; c <= DEF_ACC_CYC; c++) begin
      drive((c == 3), 0, 0, 16'h0000);
      chk($sformatf("reload_c%0d", c), mk(0, 0, 1, 0, 0, 1, acc_pos[c-1], acc_neg[c-1], 16'h010C, 12));
      step();
    end
    drive(0, 0, 0, 16'h0000);
    chk("reload_entry", mk(1, 0, 0, 1, 1, 1, 7, 5, 16'h010C, 12));

    // Abort a partial load with reset
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 1, 16'(16'h0200 + k));
      step();
    end
    chk("abort_n5", mk(1, 0, 0, 1, 0, 0, 3, 0, 16'h0205, 5));
    drive(0, 0, 0, 16'h0000);
    #2 rst_n = 1'b0;
    #1 chk("abort_reset", rst_v);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    csn_lo = 0;
    for (int i = 0; i < 3 * SAMPLE_PERIOD; i++) begin
      drive(0, (i % SAMPLE_PERIOD == 0), 0, 16'h0000);
      step();
      if (bus.oCsnRam == 1'b0) csn_lo++;
    end
    drive(0, 0, 0, 16'h0000);
    n_tests++;
    if (csn_lo != 0) begin
      n_fail++;
      $display("FAIL abort_no_acc: csn low cycles got %0d expected 0", csn_lo);
    end
    chk("abort_idle", rst_v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_coeff_seq_ctrl.md
# fir_coeff_seq_ctrl

Sequencer for the reconfigurable FIR filter's coefficient SRAMs (positive and negative banks). It takes a host coefficient stream and writes each coefficient to the correct bank and address. During filtering it sweeps the read addresses of both banks once per 600 kHz sample. It replaces hand-driven RAM control and drives the filter's iCoeffiUpdateFlag, iCsnRam, iWrnRam, iAddrRam_pos, iAddrRam_neg, iWrDtRam and iNumOfCoeff inputs directly.

## Interface
- P_NUM_COEFF, 12: coefficients per load (even, 2..14).
- P_POS_TAPS, 7: positive-bank read taps per sample (P_NUM_COEFF/2+1).
- P_NEG_TAPS, 5: negative-bank read taps per sample (P_NUM_COEFF/2-1).
- P_ACC_CYC, 8: cycles per sample with oCsnRam low (≥ P_POS_TAPS+1).
- P_SAMPLE_PERIOD, 20: clocks per sample enable (12 MHz / 600 kHz).
- iClk_12M  in  1  system clock, single clock domain.
- iRsn  in  1  reset, asynchronous, active-low.
- iEnSample_600k  in  1  one-cycle sample strobe.
- iLoadStart  in  1  pulse: begin coefficient load.
- iCoeffValid  in  1  host coefficient valid.
- iCoeffData  in  16  signed coefficient, h(1) first.
- oCoeffReady  out  1  controller accepts iCoeffData this cycle.
- oLoadDone  out  1  one-cycle pulse after the last coefficient is written.
- oRunEn  out  1  a valid coefficient set is loaded.
- oCoeffiUpdateFlag, oCsnRam, oWrnRam  out  1 each  filter RAM control.
- oAddrRam_pos, oAddrRam_neg  out  4 each  bank addresses.
- oWrDtRam  out  16  write data.
- oNumOfCoeff  out  6  coefficient index.

## Operation
- Reset values: oCsnRam=1, oWrnRam=1, oCoeffiUpdateFlag=0, oCoeffReady=0, oLoadDone=0, oRunEn=0. All address and data outputs and oNumOfCoeff are 0. State is IDLE.
- **IDLE → LOAD** on iLoadStart.
  - oRunEn clears.
  - Coefficient counter n resets to 0.
  - oCoeffiUpdateFlag=1 for the whole of LOAD.
- **LOAD** keeps oCoeffReady=1.
  - A coefficient transfers on iCoeffValid&oCoeffReady.
  - On each transfer, n increments. The next cycle drives oCsnRam=0, oWrnRam=0, oWrDtRam=data, oNumOfCoeff=n.
  - Odd n: oAddrRam_pos=(n+1)/2, oAddrRam_neg=0.
  - Even n<P_NUM_COEFF: oAddrRam_neg=n/2, oAddrRam_pos=0.
  - n=P_NUM_COEFF (centre tap): oAddrRam_pos=P_POS_TAPS, oAddrRam_neg=0.
  - Cycles without a transfer drive oCsnRam=1 and oWrnRam=1.
- **LOAD → RUN_WAIT** after transfer number P_NUM_COEFF.
  - oCoeffReady drops on the cycle the last word is accepted.
  - oLoadDone and oRunEn assert with the final write cycle.
  - oCoeffiUpdateFlag drops the cycle after that.
- **RUN_WAIT → ACC** on iEnSample_600k.
- **ACC** lasts P_ACC_CYC cycles, counted by c=1..P_ACC_CYC.
  - oCsnRam=0 and oWrnRam=1 throughout.
  - oAddrRam_pos = c for c ≤ P_POS_TAPS, else holds P_POS_TAPS.
  - oAddrRam_neg = c for c ≤ P_NEG_TAPS, else holds P_NEG_TAPS.
- **ACC → RUN_WAIT** after the last ACC cycle.
  - oCsnRam=1.
  - Addresses hold their last values.
- iEnSample_600k in IDLE or LOAD is ignored.
- iEnSample_600k during ACC is counted as an overrun and dropped; the sweep is not restarted.
- iLoadStart during ACC is latched and taken when ACC ends. iLoadStart in RUN_WAIT is taken immediately.
- iLoadStart during LOAD restarts the load at n=0.
- Reset mid-load leaves oRunEn=0. Filtering stays disabled until a complete load finishes.

## Timing
- All outputs are registered.
- Write latency: 1 cycle from accepting a coefficient to it appearing on the RAM ports.
- ACC starts on the cycle after the strobe. oAddrRam_pos=1 and oAddrRam_neg=1 appear 1 cycle after iEnSample_600k.
- With the default parameters, a sample uses 8 ACC cycles plus 12 idle cycles. Margin to the next strobe is 11 cycles.
- A back-to-back load, with iCoeffValid held high, finishes in P_NUM_COEFF+1 cycles after iLoadStart.
- n is 5 bits internally and oNumOfCoeff is zero-extended to 6 bits. c is 4 bits.

## Structure
- Package fir_ctrl_pkg holds:
  - the state encoding (IDLE, LOAD, RUN_WAIT, ACC);
  - the default tap counts;
  - the sample period.
- Sub-module fir_tap_addr_gen holds the ACC cycle counter and saturating pos/neg address counters, driven by start/clear. The top level holds the FSM, the load counter and the bank/address mapping.

## Test plan
- **Reset.** Assert iRsn=0 for 2 cycles mid-clock → all outputs at their reset values immediately; oRunEn=0.
- **Full load.** Stream 0x0003, 0x0006, 0x0007, 0x000B, …, 0x01F4 back-to-back →
  - pos writes at addresses 1..6 then 7 (data 0x01F4);
  - neg writes at addresses 1..5;
  - oNumOfCoeff steps 1..12;
  - oLoadDone pulses once with the 12th write.
- **Stalled load.** Deassert iCoeffValid for 3 cycles after coefficient 4 → oCsnRam=1 during the gap; addresses resume at pos 3; the total count is still 12.
- **Run sweep.** Issue iEnSample_600k every 20 clocks after the load →
  - each strobe produces 8 cycles of oCsnRam=0;
  - pos addresses 1..7 and neg addresses 1..5 on consecutive cycles;
  - oWrnRam stays 1.
- **Overrun.** Issue a strobe 4 cycles into ACC → the sweep is unaffected, with no restart, and the next strobe sweeps normally.
- **Reload and abort.** Issue iLoadStart during ACC → the load starts after cycle 8. Reset after 5 coefficients → oRunEn stays 0 and strobes produce no ACC.
